// File: rtl/sck_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | sck_serializer                                                             |
// | Frames a WIDTH-bit word onto cs_n/sck_out/sdo, paced by a registered sck.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sck_serializer #(
    parameter int WIDTH     = 8,
    parameter int CS_GAP    = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             cs_n,
    output logic             sck_out,
    output logic             sdo,
    output logic             done
);

    localparam int c_BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARM   = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'(CS_GAP);
    localparam logic [c_GW-1:0] c_GAP_ONE  = c_GW'(1);

    logic [1:0]       r_state;
    logic             r_sck_d;
    logic [WIDTH-1:0] r_shreg;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [c_GW-1:0]  r_gap_cnt;

    logic             w_fall;
    logic [WIDTH-1:0] w_shifted;
    logic             w_first_bit;
    logic             w_next_bit;

    // Only falling edges advance state; data therefore settles a half period before each rise.
    assign w_fall      = ~sck & r_sck_d;
    assign w_shifted   = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
    assign w_first_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_next_bit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_sck_d   <= 1'b0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            tx_ready  <= 1'b1;
            cs_n      <= 1'b1;
            sck_out   <= 1'b0;
            sdo       <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_sck_d <= sck;
            sck_out <= (r_state == c_ST_SHIFT) ? r_sck_d : 1'b0;
            done    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_shreg  <= tx_data;
                        tx_ready <= 1'b0;
                        r_state  <= c_ST_ARM;
                    end
                end
                c_ST_ARM: begin
                    if (w_fall) begin
                        cs_n      <= 1'b0;
                        sdo       <= w_first_bit;
                        r_bit_cnt <= c_BIT_LAST;
                        r_state   <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_fall) begin
                        if (r_bit_cnt != '0) begin
                            r_shreg   <= w_shifted;
                            sdo       <= w_next_bit;
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end else begin
                            cs_n <= 1'b1;
                            sdo  <= 1'b0;
                            done <= 1'b1;
                            if (CS_GAP == 0) begin
                                tx_ready <= 1'b1;
                                r_state  <= c_ST_IDLE;
                            end else begin
                                r_gap_cnt <= c_GAP_LOAD;
                                r_state   <= c_ST_GAP;
                            end
                        end
                    end
                end
                c_ST_GAP: begin
                    if (w_fall) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                        if (r_gap_cnt == c_GAP_ONE) begin
                            tx_ready <= 1'b1;
                            r_state  <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_ready <= 1'b1;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sck_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sck_serializer                                                          |
// | Two instances: A = MSB-first, CS_GAP=1; B = LSB-first, CS_GAP=0.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sck_serializer;

    localparam int W     = 8;
    localparam int LIMIT = 2000;
    localparam int NFRM  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    int unsigned div = 0;

    logic [W-1:0] tx_data  [2];
    logic         tx_valid [2];
    logic         tx_ready [2];
    logic         cs_n     [2];
    logic         sck_out  [2];
    logic         sdo      [2];
    logic         done     [2];

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    // 9 clk high / 9 clk low, registered in the clk domain like the real divider
    always @(posedge clk) begin
        if (div == 8) begin
            div <= 0;
            sck <= ~sck;
        end else begin
            div <= div + 1;
        end
    end

    sck_serializer #(.WIDTH(W), .CS_GAP(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sck(sck),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .cs_n(cs_n[0]), .sck_out(sck_out[0]), .sdo(sdo[0]), .done(done[0])
    );

    sck_serializer #(.WIDTH(W), .CS_GAP(0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sck(sck),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .cs_n(cs_n[1]), .sck_out(sck_out[1]), .sdo(sdo[1]), .done(done[1])
    );

    // Pin-level observer: decodes frames the way a logic analyser would
    logic        m_psck [2];
    logic        m_pcs  [2];
    logic        m_seen [2];
    logic [31:0] m_acc  [2];
    int          m_nb   [2];
    int          m_lo   [2];
    int          m_hi   [2];
    int          frm_cnt  [2];
    int          gap_last [2];
    int          done_cnt [2];
    int          v_done   [2];
    int          v_idle   [2];
    int          v_ready  [2];
    logic [31:0] frm_word [2][NFRM];
    int          frm_nb   [2][NFRM];
    int          frm_len  [2][NFRM];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs_n[k] === 1'b1) begin
                if (m_pcs[k] !== 1'b1) begin
                    if (frm_cnt[k] < NFRM) begin
                        frm_word[k][frm_cnt[k]] = m_acc[k];
                        frm_nb[k][frm_cnt[k]]   = m_nb[k];
                        frm_len[k][frm_cnt[k]]  = m_lo[k];
                    end
                    frm_cnt[k]++;
                    m_seen[k] = 1'b1;
                    m_hi[k]   = 1;
                    m_acc[k]  = '0;
                    m_nb[k]   = 0;
                end else begin
                    m_hi[k]++;
                end
                if (sck_out[k] === 1'b1 && m_hi[k] >= 2) v_idle[k]++;
            end else if (cs_n[k] === 1'b0) begin
                if (m_pcs[k] === 1'b1) begin
                    if (m_seen[k]) gap_last[k] = m_hi[k];
                    m_lo[k] = 1;
                end else begin
                    m_lo[k]++;
                end
                if (sck_out[k] === 1'b1 && m_psck[k] === 1'b0) begin
                    m_acc[k] = {m_acc[k][30:0], sdo[k]};
                    m_nb[k]++;
                end
                if (tx_ready[k] === 1'b1) v_ready[k]++;
                if (done[k] === 1'b1) v_done[k]++;
            end
            if (done[k] === 1'b1) done_cnt[k]++;
            m_psck[k] = sck_out[k];
            m_pcs[k]  = cs_n[k];
        end
    end

    // Reference: the order bits must appear on the wire, packed first-bit-highest
    function automatic logic [31:0] expect_seq(input logic [W-1:0] w, input bit msb);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r = {r[30:0], (msb ? w[W-1-i] : w[i])};
        return r;
    endfunction

    task automatic clear_mon(input int k);
        @(posedge clk);
        frm_cnt[k]  = 0;
        gap_last[k] = -1;
        done_cnt[k] = 0;
        v_done[k]   = 0;
        v_idle[k]   = 0;
        v_ready[k]  = 0;
    endtask

    task automatic send(input int k, input logic [W-1:0] w, output bit ok);
        int n;
        n = 0;
        tx_data[k]  = w;
        tx_valid[k] = 1'b1;
        while (tx_ready[k] !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        ok = (n < LIMIT);
        @(negedge clk);
        tx_valid[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int n, output bit ok);
        int c;
        c = 0;
        while (frm_cnt[k] < n && c < LIMIT * 8) begin
            @(negedge clk);
            c++;
        end
        ok = (frm_cnt[k] >= n);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = '0;
            m_psck[k]   = 1'b0;
            m_pcs[k]    = 1'b1;
            m_seen[k]   = 1'b0;
            m_acc[k]    = '0;
            m_nb[k]     = 0;
            m_lo[k]     = 0;
            m_hi[k]     = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if ({tx_ready[k], cs_n[k], sck_out[k], sdo[k], done[k]} !== 5'b11000) begin
                    bad++;
                    $display("FAIL reset_idle dut%0d cyc%0d: ready,cs_n,sck_out,sdo,done=%b want 11000",
                             k, c, {tx_ready[k], cs_n[k], sck_out[k], sdo[k], done[k]});
                end
            end
        end
        clear_mon(0);
        clear_mon(1);
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_mon(0);
        @(negedge clk);
        send(0, 8'hA5, ok);
        wait_frames(0, 1, ok);
        total++; if (!ok || frm_cnt[0] != 1) begin bad++; $display("FAIL single_count: got %0d want 1", frm_cnt[0]); end
        total++; if (frm_nb[0][0] != 8) begin bad++; $display("FAIL single_rises: got %0d want 8", frm_nb[0][0]); end
        total++; if (frm_word[0][0] !== expect_seq(8'hA5, 1'b1)) begin bad++; $display("FAIL single_bits: got %h want %h", frm_word[0][0], expect_seq(8'hA5, 1'b1)); end
        total++; if (frm_len[0][0] != 144) begin bad++; $display("FAIL single_cs_len: got %0d want 144", frm_len[0][0]); end
        total++; if (done_cnt[0] != 1 || v_done[0] != 0) begin bad++; $display("FAIL single_done: got %0d (low=%0d) want 1 (low=0)", done_cnt[0], v_done[0]); end
        total++; if (v_idle[0] != 0) begin bad++; $display("FAIL single_sck_idle: got %0d want 0", v_idle[0]); end
        total++; if (v_ready[0] != 0) begin bad++; $display("FAIL single_ready_busy: got %0d want 0", v_ready[0]); end
        repeat (60) @(negedge clk);
        total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL single_ready_back: got %b want 1", tx_ready[0]); end
    endtask

    task automatic test_lsb_first();
        bit ok;
        clear_mon(1);
        @(negedge clk);
        send(1, 8'h01, ok);
        wait_frames(1, 1, ok);
        repeat (40) @(negedge clk);
        total++; if (!ok || frm_cnt[1] != 1) begin bad++; $display("FAIL lsb_count: got %0d want 1", frm_cnt[1]); end
        total++; if (frm_word[1][0] !== expect_seq(8'h01, 1'b0) || frm_nb[1][0] != 8) begin bad++; $display("FAIL lsb_bits: got %h/%0d want %h/8", frm_word[1][0], frm_nb[1][0], expect_seq(8'h01, 1'b0)); end
        total++; if (frm_len[1][0] != 144) begin bad++; $display("FAIL lsb_cs_len: got %0d want 144", frm_len[1][0]); end
        total++; if (v_idle[1] != 0 || sck_out[1] !== 1'b0) begin bad++; $display("FAIL lsb_sck_idle: got %0d/%b want 0/0", v_idle[1], sck_out[1]); end
        total++; if (done_cnt[1] != 1 || v_done[1] != 0) begin bad++; $display("FAIL lsb_done: got %0d want 1", done_cnt[1]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        clear_mon(0);
        @(negedge clk);
        tx_data[0]  = 8'hFF;
        tx_valid[0] = 1'b1;
        n = 0;
        while (tx_ready[0] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_data[0] = 8'h00;
        n = 0;
        while (tx_ready[0] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        total++; if (n >= LIMIT || done_cnt[0] != 1) begin bad++; $display("FAIL b2b_accept_after_done: got done=%0d want 1", done_cnt[0]); end
        @(negedge clk);
        tx_valid[0] = 1'b0;
        wait_frames(0, 2, ok);
        total++; if (!ok || frm_cnt[0] != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", frm_cnt[0]); end
        total++; if (frm_word[0][0] !== expect_seq(8'hFF, 1'b1) || frm_word[0][1] !== expect_seq(8'h00, 1'b1)) begin bad++; $display("FAIL b2b_words: got %h,%h want ff,00", frm_word[0][0], frm_word[0][1]); end
        total++; if (gap_last[0] != 36) begin bad++; $display("FAIL b2b_gap: got %0d want 36", gap_last[0]); end
        total++; if (done_cnt[0] != 2 || v_ready[0] != 0) begin bad++; $display("FAIL b2b_done: got %0d (busy ready %0d) want 2 (0)", done_cnt[0], v_ready[0]); end
    endtask

    task automatic test_busy();
        bit ok;
        int n;
        logic [W-1:0] w;
        w = W'($urandom);
        clear_mon(0);
        @(negedge clk);
        send(0, w, ok);
        n = 0;
        while (cs_n[0] !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
        for (int p = 0; p < 5; p++) begin
            repeat (20) @(negedge clk);
            tx_data[0]  = 8'h3C;
            tx_valid[0] = 1'b1;
            total++; if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL busy_ready p%0d: got %b want 0", p, tx_ready[0]); end
            @(negedge clk);
            tx_valid[0] = 1'b0;
        end
        wait_frames(0, 1, ok);
        repeat (100) @(negedge clk);
        total++; if (frm_cnt[0] != 1 || done_cnt[0] != 1) begin bad++; $display("FAIL busy_extra_frame: got %0d frames %0d done want 1/1", frm_cnt[0], done_cnt[0]); end
        total++; if (frm_word[0][0] !== expect_seq(w, 1'b1)) begin bad++; $display("FAIL busy_word: got %h want %h", frm_word[0][0], expect_seq(w, 1'b1)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        clear_mon(0);
        @(negedge clk);
        send(0, W'($urandom), ok);
        n = 0;
        while (!(cs_n[0] === 1'b0 && m_nb[0] == 4) && n < LIMIT) begin @(negedge clk); n++; end
        total++; if (n >= LIMIT) begin bad++; $display("FAIL rstmid_timeout: got %0d rises want 4", m_nb[0]); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({tx_ready[0], cs_n[0], sck_out[0], sdo[0], done[0]} !== 5'b11000) begin bad++; $display("FAIL rstmid_outputs: got %b want 11000", {tx_ready[0], cs_n[0], sck_out[0], sdo[0], done[0]}); end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (done_cnt[0] != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt[0]); end
        clear_mon(0);
        @(negedge clk);
        send(0, 8'h81, ok);
        wait_frames(0, 1, ok);
        total++; if (frm_word[0][0] !== expect_seq(8'h81, 1'b1) || frm_nb[0][0] != 8 || frm_len[0][0] != 144) begin bad++; $display("FAIL rstmid_next_frame: got %h/%0d/%0d want 81/8/144", frm_word[0][0], frm_nb[0][0], frm_len[0][0]); end
        total++; if (done_cnt[0] != 1) begin bad++; $display("FAIL rstmid_next_done: got %0d want 1", done_cnt[0]); end
    endtask

    task automatic test_random();
        bit ok;
        logic [W-1:0] exp_q[$];
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            clear_mon(k);
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                exp_q.push_back(W'($urandom));
                send(k, exp_q[i], ok);
            end
            wait_frames(k, 6, ok);
            for (int i = 0; i < 6; i++) begin
                total++;
                if (frm_word[k][i] !== expect_seq(exp_q[i], (k == 0)) || frm_nb[k][i] != 8 || frm_len[k][i] != 144) begin
                    bad++;
                    $display("FAIL random dut%0d f%0d: got %h/%0d/%0d want %h/8/144", k, i,
                             frm_word[k][i], frm_nb[k][i], frm_len[k][i], expect_seq(exp_q[i], (k == 0)));
                end
            end
            total++;
            if (gap_last[k] != ((k == 0) ? 36 : 18)) begin
                bad++;
                $display("FAIL random_gap dut%0d: got %0d want %0d", k, gap_last[k], (k == 0) ? 36 : 18);
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_lsb_first();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
